// File: rtl/dac_run_sequencer.sv
// dac_run_sequencer
//   Per-run timing controller between the PS GPIO control path and the
//   DAC/ADC datapaths. A synchronised trigger latches the run configuration
//   and walks PRE -> RUN -> POST -> DONE, skipping any zero-length phase.
//   Outside RUN the DAC mux is steered to the locking waveform (if enabled).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   trigger             raw asynchronous trigger line
//   *_cycles            phase lengths in clk cycles (CFG_W bits each)
//   mask_enable         enables wave_first / wave_last strobes
//   lock_enable         enables locking waveform select outside RUN
//   dac_play            high in every RUN cycle
//   adc_capture         high for the first min(adc, run) RUN cycles
//   wave_first/last     first/last RUN cycle strobes
//   lock_sel            locking waveform mux select
//   busy, done          run in progress / one-cycle completion pulse
//   trig_overrun        sticky: trigger seen while busy
module dac_run_sequencer #(
  parameter int CFG_W       = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [CFG_W-1:0] pre_delay_cycles,
  input  logic [CFG_W-1:0] run_cycles,
  input  logic [CFG_W-1:0] post_delay_cycles,
  input  logic [CFG_W-1:0] adc_run_cycles,
  input  logic             mask_enable,
  input  logic             lock_enable,
  output logic             dac_play,
  output logic             adc_capture,
  output logic             wave_first,
  output logic             wave_last,
  output logic             lock_sel,
  output logic             busy,
  output logic             done,
  output logic             trig_overrun
);

  typedef enum logic [2:0] {IDLE, PRE, RUN, POST, DONE} state_t;

  state_t state, nxt;
  logic [CFG_W-1:0] cnt, cnt_nxt, adc_cnt;
  logic [CFG_W-1:0] run_s, post_s, adc_s;
  logic mask_s, lock_s;

  logic [SYNC_STAGES-1:0] sync;
  logic edge_q, trig_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      edge_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], trigger};
      edge_q <= sync[SYNC_STAGES-1];
    end
  end

  assign trig_pulse = sync[SYNC_STAGES-1] & ~edge_q;

  // On the accepting cycle the shadows are not yet loaded, so the
  // effective configuration comes straight from the inputs.
  logic             latch;
  logic [CFG_W-1:0] c_run, c_post, c_adc;
  logic             c_mask, c_lock;

  assign latch  = (state == IDLE) && trig_pulse;
  assign c_run  = latch ? run_cycles        : run_s;
  assign c_post = latch ? post_delay_cycles : post_s;
  assign c_adc  = latch ? adc_run_cycles    : adc_s;
  assign c_mask = latch ? mask_enable       : mask_s;
  assign c_lock = latch ? lock_enable       : lock_s;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (trig_pulse) begin
        if (pre_delay_cycles != '0) begin
          nxt = PRE;  cnt_nxt = pre_delay_cycles - CFG_W'(1);
        end else if (c_run != '0) begin
          nxt = RUN;  cnt_nxt = c_run - CFG_W'(1);
        end else if (c_post != '0) begin
          nxt = POST; cnt_nxt = c_post - CFG_W'(1);
        end else begin
          nxt = DONE; cnt_nxt = '0;
        end
      end
      PRE: if (cnt == '0) begin
        if (c_run != '0) begin
          nxt = RUN;  cnt_nxt = c_run - CFG_W'(1);
        end else if (c_post != '0) begin
          nxt = POST; cnt_nxt = c_post - CFG_W'(1);
        end else begin
          nxt = DONE; cnt_nxt = '0;
        end
      end else cnt_nxt = cnt - CFG_W'(1);
      RUN: if (cnt == '0) begin
        if (c_post != '0) begin
          nxt = POST; cnt_nxt = c_post - CFG_W'(1);
        end else begin
          nxt = DONE; cnt_nxt = '0;
        end
      end else cnt_nxt = cnt - CFG_W'(1);
      POST: if (cnt == '0) begin
        nxt = DONE; cnt_nxt = '0;
      end else cnt_nxt = cnt - CFG_W'(1);
      DONE: begin
        nxt = IDLE; cnt_nxt = '0;
      end
      default: begin
        nxt = IDLE; cnt_nxt = '0;
      end
    endcase
  end

  logic enter_run;
  assign enter_run = (nxt == RUN) && (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      adc_cnt      <= '0;
      run_s        <= '0;
      post_s       <= '0;
      adc_s        <= '0;
      mask_s       <= 1'b0;
      lock_s       <= 1'b0;
      dac_play     <= 1'b0;
      adc_capture  <= 1'b0;
      wave_first   <= 1'b0;
      wave_last    <= 1'b0;
      lock_sel     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      trig_overrun <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        run_s  <= run_cycles;
        post_s <= post_delay_cycles;
        adc_s  <= adc_run_cycles;
        mask_s <= mask_enable;
        lock_s <= lock_enable;
      end
      // Capture window runs off its own counter; leaving RUN always closes
      // it, which bounds it by run length.
      if (enter_run) begin
        adc_capture <= (c_adc != '0);
        adc_cnt     <= c_adc - CFG_W'(1);
      end else if (nxt == RUN) begin
        if (adc_capture) begin
          if (adc_cnt == '0) adc_capture <= 1'b0;
          else               adc_cnt     <= adc_cnt - CFG_W'(1);
        end
      end else begin
        adc_capture <= 1'b0;
      end
      dac_play     <= (nxt == RUN);
      wave_first   <= c_mask && enter_run;
      wave_last    <= c_mask && (nxt == RUN) && (cnt_nxt == '0);
      lock_sel     <= (nxt == IDLE) ? lock_enable : (c_lock && (nxt != RUN));
      busy         <= (nxt != IDLE);
      done         <= (nxt == DONE);
      trig_overrun <= trig_overrun | (trig_pulse && (state != IDLE));
    end
  end

endmodule

// File: tb/tb_dac_run_sequencer.sv
module tb_dac_run_sequencer;
  localparam int CFG_W = 256;

  logic clk = 1'b0;
  logic rst;
  logic trigger;
  logic [CFG_W-1:0] pre_delay_cycles, run_cycles, post_delay_cycles, adc_run_cycles;
  logic mask_enable, lock_enable;
  logic dac_play, adc_capture, wave_first, wave_last, lock_sel, busy, done, trig_overrun;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_dp, m_ac, m_wf, m_wl, m_ls, m_bz, m_dn;

  dac_run_sequencer #(.CFG_W(CFG_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .pre_delay_cycles(pre_delay_cycles), .run_cycles(run_cycles),
    .post_delay_cycles(post_delay_cycles), .adc_run_cycles(adc_run_cycles),
    .mask_enable(mask_enable), .lock_enable(lock_enable),
    .dac_play(dac_play), .adc_capture(adc_capture), .wave_first(wave_first),
    .wave_last(wave_last), .lock_sel(lock_sel), .busy(busy), .done(done),
    .trig_overrun(trig_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_masks();
    m_dp = '0; m_ac = '0; m_wf = '0; m_wl = '0; m_ls = '0; m_bz = '0; m_dn = '0;
  endtask

  task automatic sample(input int i);
    m_dp[i] = dac_play;  m_ac[i] = adc_capture; m_wf[i] = wave_first;
    m_wl[i] = wave_last; m_ls[i] = lock_sel;    m_bz[i] = busy;
    m_dn[i] = done;
  endtask

  // Raise trigger at a negedge, wait (bounded) for busy, then drop it.
  task automatic start_run(input string tag);
    int n;
    trigger = 1'b1;
    n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_seen"}, {31'b0, busy}, 32'h1);
    trigger = 1'b0;
  endtask

  task automatic run_capture(input string tag, input int ncyc);
    clr_masks();
    start_run(tag);
    for (int i = 0; i < ncyc; i++) begin
      sample(i);
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input int pre, input int run, input int post, input int adc,
                         input logic mask, input logic lock);
    pre_delay_cycles  = CFG_W'(pre);
    run_cycles        = CFG_W'(run);
    post_delay_cycles = CFG_W'(post);
    adc_run_cycles    = CFG_W'(adc);
    mask_enable       = mask;
    lock_enable       = lock;
  endtask

  initial begin
    logic [7:0] outs;
    logic       any_done, any_busy;
    rst = 1'b1;
    trigger = 1'b0;
    set_cfg(0, 0, 0, 0, 1'b0, 1'b0);
    #12;
    outs = {dac_play, adc_capture, wave_first, wave_last, lock_sel, busy, done, trig_overrun};
    chk("reset_outputs", {24'b0, outs}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: pre=3 run=5 post=2 adc=3 mask=1
    set_cfg(3, 5, 2, 3, 1'b1, 1'b0);
    run_capture("t1", 14);
    chk("t1_busy", m_bz, 32'h7FF);
    chk("t1_dac",  m_dp, 32'h0F8);
    chk("t1_adc",  m_ac, 32'h038);
    chk("t1_wf",   m_wf, 32'h008);
    chk("t1_wl",   m_wl, 32'h080);
    chk("t1_done", m_dn, 32'h400);
    chk("t1_lock", m_ls, 32'h0);
    chk("t1_ovr",  {31'b0, trig_overrun}, 32'h0);

    // 2: run=1 only, mask=1
    set_cfg(0, 1, 0, 0, 1'b1, 1'b0);
    run_capture("t2", 6);
    chk("t2_busy", m_bz, 32'h3);
    chk("t2_dac",  m_dp, 32'h1);
    chk("t2_wf",   m_wf, 32'h1);
    chk("t2_wl",   m_wl, 32'h1);
    chk("t2_done", m_dn, 32'h2);

    // 3: all zero -> straight to DONE
    set_cfg(0, 0, 0, 0, 1'b1, 1'b0);
    run_capture("t3", 5);
    chk("t3_busy", m_bz, 32'h1);
    chk("t3_dac",  m_dp, 32'h0);
    chk("t3_done", m_dn, 32'h1);

    // 4: adc longer than run -> clipped to run
    set_cfg(0, 4, 0, 10, 1'b0, 1'b0);
    run_capture("t4", 8);
    chk("t4_dac",  m_dp, 32'hF);
    chk("t4_adc",  m_ac, 32'hF);
    chk("t4_wf",   m_wf, 32'h0);
    chk("t4_done", m_dn, 32'h10);

    // 5: retrigger and config change mid-run
    set_cfg(0, 6, 0, 0, 1'b0, 1'b0);
    clr_masks();
    start_run("t5");
    for (int i = 0; i < 12; i++) begin
      sample(i);
      if (i == 1) run_cycles = CFG_W'(2);
      if (i == 2) trigger = 1'b1;
      if (i == 5) trigger = 1'b0;
      @(negedge clk);
    end
    chk("t5_busy", m_bz, 32'h7F);
    chk("t5_dac",  m_dp, 32'h3F);
    chk("t5_ovr",  {31'b0, trig_overrun}, 32'h1);
    repeat (4) @(negedge clk);
    run_capture("t5b", 6);
    chk("t5b_dac", m_dp, 32'h3);
    chk("t5b_ovr", {31'b0, trig_overrun}, 32'h1);

    // 6: lock select, masks disabled, reset mid-run
    set_cfg(2, 4, 1, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_lock_idle", {31'b0, lock_sel}, 32'h1);
    clr_masks();
    start_run("t6");
    for (int i = 0; i < 4; i++) begin
      sample(i);
      @(negedge clk);
    end
    chk("t6_lock", m_ls[3:0], 32'h3);
    chk("t6_dac",  m_dp[3:0], 32'hC);
    chk("t6_wfwl", m_wf | m_wl, 32'h0);
    rst = 1'b1;
    #1;
    outs = {dac_play, adc_capture, wave_first, wave_last, lock_sel, busy, done, trig_overrun};
    chk("t6_rst_outputs", {24'b0, outs}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_done |= done;
      any_busy |= busy;
    end
    chk("t6_no_done", {31'b0, any_done}, 32'h0);
    chk("t6_no_busy", {31'b0, any_busy}, 32'h0);
    chk("t6_lock_after_rst", {31'b0, lock_sel}, 32'h1);

    set_cfg(1, 2, 1, 1, 1'b1, 1'b0);
    run_capture("t7", 8);
    chk("t7_busy", m_bz, 32'h1F);
    chk("t7_dac",  m_dp, 32'h6);
    chk("t7_adc",  m_ac, 32'h2);
    chk("t7_wf",   m_wf, 32'h2);
    chk("t7_wl",   m_wl, 32'h4);
    chk("t7_done", m_dn, 32'h10);
    chk("t7_ovr",  {31'b0, trig_overrun}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
